// File: rtl/data_mem_rv32_if.sv
// Load/store bus between the LSU (master) and the RV32I data memory (slave).
// Carries the request, byte address, store data and the registered load/fault response.
interface data_mem_rv32_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  write_en;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           write_data;
  logic [31:0]           data;
  logic                  rvalid;
  logic                  fault;
  logic                  busy;

  modport master (
    output req, write_en, funct3, addr, write_data,
    input  data, rvalid, fault, busy
  );

  modport slave (
    input  req, write_en, funct3, addr, write_data,
    output data, rvalid, fault, busy
  );
endinterface

// File: rtl/data_mem_rv32.sv
// Byte-addressable RV32I data memory: sub-word load/store with extension, registered
// load response, misaligned/illegal-access fault pulse and a sequenced clear after reset.
module data_mem_rv32 #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  data_mem_rv32_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [IDX_W-1:0]      clr_idx;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           data_q;
  logic                  rvalid_q;
  logic                  fault_q;
  logic                  busy_q;

  logic [ADDR_WIDTH-1:0] addr;
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic                  legal;
  logic                  misaligned;
  logic                  accept;
  logic                  bad;
  logic                  do_store;
  logic                  do_load;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;

  assign addr     = bus.addr;
  assign word_idx = addr[IDX_W+1:2];
  assign lane     = addr[1:0];

  // Address bits above the word index wrap and are intentionally ignored.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W+2];
  end

  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.write_en;
      default:                legal = 1'b0;
    endcase
    misaligned = (bus.funct3[1:0] == 2'b01 && addr[0]) ||
                 (bus.funct3[1:0] == 2'b10 && lane != 2'b00);
    accept   = (state == READY) && bus.req;
    bad      = accept && (!legal || misaligned);
    do_store = accept && legal && !misaligned && bus.write_en;
    do_load  = accept && legal && !misaligned && !bus.write_en;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = bus.write_data;
    case (bus.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.write_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.write_data;
      end
    endcase
  end

  always_comb begin
    rd_word = mem[word_idx];
    rd_byte = rd_word[7:0];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_val = {24'h000000, rd_byte};
      3'b101:  load_val = {16'h0000, rd_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      busy_q   <= 1'b1;
      data_q   <= '0;
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state  <= READY;
            busy_q <= 1'b0;
          end
        end
        default: begin
          if (bad) begin
            fault_q <= 1'b1;
          end else if (do_load) begin
            rvalid_q <= 1'b1;
            data_q   <= load_val;
          end
        end
      endcase
    end
  end

  // Gated on the registered state rather than rst: while rst is held the state is
  // already CLEAR with index 0, so word 0 is re-zeroed, which the sequence does anyway.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bus.data   = data_q;
  assign bus.rvalid = rvalid_q;
  assign bus.fault  = fault_q;
  assign bus.busy   = busy_q;
endmodule
